morse_char_decoder: RTL and testbench



---
 rtl/morse_char_decoder_if.sv | 10 +
 rtl/morse_char_decoder.sv | 170 +++++++++++++++++
 tb/tb_morse_char_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_char_decoder_if.sv
// Character stream from the Morse decoder to the display/UART sink.
// The decoder drives char_out/char_valid and the sink answers with char_ready.
interface morse_char_decoder_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/morse_char_decoder.sv
// Walks a captured buffer of Morse codes from oldest (top slot) to newest,
// skips empty slots and streams one ASCII character per occupied slot.
module morse_char_decoder #(
  parameter int         SLOTS        = 16,
  parameter int         SLOT_W       = 10,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [SLOTS*SLOT_W-1:0] seq_in,
  morse_char_decoder_if.master    stream,
  output logic                    busy,
  output logic                    done,
  output logic [4:0]              char_count
);

  localparam int IDX_W = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                  state, state_next;
  logic [SLOTS*SLOT_W-1:0] buffer;
  logic [IDX_W-1:0]        index;
  logic [SLOT_W-1:0]       slot;
  logic                    slot_empty;
  logic                    capture, scan_step, take_char, accept, dec_index;

  // Decode one slot: dashes are packed left-aligned (first symbol in bit 4)
  // together with the code length, so the table lookup is a single case.
  function automatic logic [7:0] decode_slot(input logic [SLOT_W-1:0] code);
    logic [1:0] sym;
    logic       pad;
    logic       bad;
    logic [2:0] len;
    logic [4:0] dashes;
    logic [7:0] ch;
    pad    = 1'b0;
    bad    = 1'b0;
    len    = 3'd0;
    dashes = 5'd0;
    for (int j = 0; j < 5; j++) begin
      sym = code[SLOT_W-1-2*j -: 2];
      if (sym == 2'b10) begin
        bad = 1'b1;
      end else if (sym == 2'b11) begin
        pad = 1'b1;
      end else if (pad) begin
        bad = 1'b1;
      end else begin
        dashes[4-j] = sym[0];
        len         = len + 3'd1;
      end
    end
    case ({len, dashes})
      {3'd2, 5'b01000}: ch = 8'h41; // A .-
      {3'd4, 5'b10000}: ch = 8'h42; // B -...
      {3'd4, 5'b10100}: ch = 8'h43; // C -.-.
      {3'd3, 5'b10000}: ch = 8'h44; // D -..
      {3'd1, 5'b00000}: ch = 8'h45; // E .
      {3'd4, 5'b00100}: ch = 8'h46; // F ..-.
      {3'd3, 5'b11000}: ch = 8'h47; // G --.
      {3'd4, 5'b00000}: ch = 8'h48; // H ....
      {3'd2, 5'b00000}: ch = 8'h49; // I ..
      {3'd4, 5'b01110}: ch = 8'h4A; // J .---
      {3'd3, 5'b10100}: ch = 8'h4B; // K -.-
      {3'd4, 5'b01000}: ch = 8'h4C; // L .-..
      {3'd2, 5'b11000}: ch = 8'h4D; // M --
      {3'd2, 5'b10000}: ch = 8'h4E; // N -.
      {3'd3, 5'b11100}: ch = 8'h4F; // O ---
      {3'd4, 5'b01100}: ch = 8'h50; // P .--.
      {3'd4, 5'b11010}: ch = 8'h51; // Q --.-
      {3'd3, 5'b01000}: ch = 8'h52; // R .-.
      {3'd3, 5'b00000}: ch = 8'h53; // S ...
      {3'd1, 5'b10000}: ch = 8'h54; // T -
      {3'd3, 5'b00100}: ch = 8'h55; // U ..-
      {3'd4, 5'b00010}: ch = 8'h56; // V ...-
      {3'd3, 5'b01100}: ch = 8'h57; // W .--
      {3'd4, 5'b10010}: ch = 8'h58; // X -..-
      {3'd4, 5'b10110}: ch = 8'h59; // Y -.--
      {3'd4, 5'b11000}: ch = 8'h5A; // Z --..
      {3'd5, 5'b11111}: ch = 8'h30; // 0
      {3'd5, 5'b01111}: ch = 8'h31; // 1
      {3'd5, 5'b00111}: ch = 8'h32; // 2
      {3'd5, 5'b00011}: ch = 8'h33; // 3
      {3'd5, 5'b00001}: ch = 8'h34; // 4
      {3'd5, 5'b00000}: ch = 8'h35; // 5
      {3'd5, 5'b10000}: ch = 8'h36; // 6
      {3'd5, 5'b11000}: ch = 8'h37; // 7
      {3'd5, 5'b11100}: ch = 8'h38; // 8
      {3'd5, 5'b11110}: ch = 8'h39; // 9
      default:          ch = UNKNOWN_CHAR;
    endcase
    if (bad) ch = UNKNOWN_CHAR;
    return ch;
  endfunction

  assign slot       = buffer[int'(index)*SLOT_W +: SLOT_W];
  assign slot_empty = (slot[SLOT_W-1 -: 2] == 2'b11);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign dec_index  = scan_step || (accept && (index != '0));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the per-cycle datapath strobes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    scan_step  = 1'b0;
    take_char  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot_empty) begin
          if (index == '0) state_next = DONE;
          else             scan_step  = 1'b1;
        end else begin
          take_char  = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (stream.char_valid && stream.char_ready) begin
          accept     = 1'b1;
          state_next = (index == '0) ? DONE : SCAN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer, slot index, output character and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer            <= '1;
      index             <= IDX_W'(SLOTS-1);
      stream.char_out   <= 8'h00;
      stream.char_valid <= 1'b0;
      char_count        <= 5'd0;
    end else begin
      if (capture) begin
        buffer     <= seq_in;
        index      <= IDX_W'(SLOTS-1);
        char_count <= 5'd0;
      end
      if (dec_index) index <= index - 1'b1;
      if (take_char) begin
        stream.char_out   <= decode_slot(slot);
        stream.char_valid <= 1'b1;
      end
      if (accept) begin
        stream.char_valid <= 1'b0;
        char_count        <= char_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Bench for morse_char_decoder: directed walks plus randomized buffers,
// checked against a string-table Morse reference model.
module tb_morse_char_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [159:0] seq_in;
  logic         busy;
  logic         done;
  logic [4:0]   char_count;

  morse_char_decoder_if intf ();

  morse_char_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .seq_in    (seq_in),
    .stream    (intf.master),
    .busy      (busy),
    .done      (done),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  string morse [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--..", "-----", ".----", "..---", "...--",
                        "....-", ".....", "-....", "--...", "---..", "----."};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: spell the slot as dots/dashes, reject illegal forms, find it in the table.
  function automatic logic [7:0] model_char(input logic [9:0] code);
    string s   = "";
    bit    pad = 1'b0;
    bit    bad = 1'b0;
    int    sym;
    for (int j = 0; j < 5; j++) begin
      sym = int'((code >> (8 - 2*j)) & 10'd3);
      if (sym == 2) bad = 1'b1;
      else if (sym == 3) pad = 1'b1;
      else if (pad) bad = 1'b1;
      else s = {s, (sym == 0) ? "." : "-"};
    end
    if (bad) return 8'h3F;
    for (int i = 0; i < 36; i++)
      if (s == morse[i]) return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
    return 8'h3F;
  endfunction

  function automatic logic [9:0] encode(input string p);
    logic [9:0] v = '1;
    for (int i = 0; i < p.len(); i++)
      v[9-2*i -: 2] = (p.getc(i) == 8'h2D) ? 2'b01 : 2'b00;
    return v;
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready low for 5 cycles per char.
  task automatic run_walk(input logic [159:0] seq, input int mode, input bit reload,
                          input int exp_first);
    logic [7:0]  q[$];
    logic [9:0]  code;
    logic [7:0]  prev_out;
    int          n, e, stalls, stall_run, first;
    bit          finished, prev_stall, rdy;
    n = 0;
    for (int k = 15; k >= 0; k--) begin
      code = seq[k*10 +: 10];
      if (code[9:8] != 2'b11) begin
        q.push_back(model_char(code));
        n++;
      end
    end
    intf.char_ready = (mode == 0);
    seq_in = seq;
    load   = 1'b1;
    step();
    load = 1'b0;
    e = 1; stalls = 0; stall_run = 0; first = -1;
    finished = 1'b0; prev_stall = 1'b0; prev_out = 8'h00;
    check("busy_after_load", 32'(busy), 32'd1);
    while (!finished && e < 400) begin
      if (prev_stall) begin
        check("stall_valid", 32'(intf.char_valid), 32'd1);
        check("stall_char", 32'(intf.char_out), 32'(prev_out));
      end
      if (intf.char_valid && first < 0) first = e;
      if (done) begin
        finished = 1'b1;
        check("char_count", 32'(char_count), 32'(n));
        check("chars_left", 32'(q.size()), 32'd0);
        check("done_edge", 32'(e), 32'(17 + n + stalls));
        if (exp_first >= 0) check("first_valid_edge", 32'(first), 32'(exp_first));
        if (n == 0) check("valid_seen", 32'(first), 32'hFFFF_FFFF);
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (stall_run >= 5);
        endcase
        intf.char_ready = rdy;
        if (intf.char_valid) begin
          if (rdy) begin
            if (q.size() == 0) check("extra_char", 32'(intf.char_out), 32'hFFFF_FFFF);
            else check("char", 32'(intf.char_out), 32'(q.pop_front()));
            stall_run = 0;
          end else begin
            stalls++;
            stall_run++;
          end
        end
        prev_stall = intf.char_valid && !rdy;
        prev_out   = intf.char_out;
        load   = reload && (e == 5);
        seq_in = (reload && (e == 5)) ? {16{10'h07F}} : seq;
        step();
        e++;
      end
    end
    if (!finished) check("walk_timeout", 32'd0, 32'd1);
    load = 1'b0;
    step();
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("count_retained", 32'(char_count), 32'(n));
  endtask

  logic [159:0] sos, seq;
  logic [9:0]   code;
  int           waited;

  initial begin
    reset = 1'b1; load = 1'b0; seq_in = '0; intf.char_ready = 1'b0;
    step(); step();
    check("rst_char_out", 32'(intf.char_out), 32'd0);
    check("rst_valid", 32'(intf.char_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(char_count), 32'd0);

    // load together with reset: reset wins
    load = 1'b1; seq_in = '0;
    step();
    reset = 1'b0; load = 1'b0;
    check("rst_load_busy", 32'(busy), 32'd0);
    step();
    check("rst_load_idle", 32'(busy), 32'd0);

    sos = '1;
    sos[29:0] = {10'h00F, 10'h15F, 10'h00F};
    run_walk(sos, 0, 1'b0, 15);

    run_walk({16{10'h07F}}, 0, 1'b0, 2);

    seq = '1; seq[159:150] = 10'h1FF;
    run_walk(seq, 2, 1'b0, 2);

    seq = '1;
    seq[159:120] = {10'h2FF, 10'h0CF, 10'h155, 10'h000};
    run_walk(seq, 0, 1'b0, 2);

    run_walk('1, 0, 1'b1, -1);

    // reset while stalled in the first EMIT
    intf.char_ready = 1'b0; seq_in = sos; load = 1'b1;
    step();
    load = 1'b0;
    waited = 0;
    while (!intf.char_valid && waited < 40) begin step(); waited++; end
    check("rst_mid_reached_emit", 32'(intf.char_valid), 32'd1);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_valid", 32'(intf.char_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(char_count), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    step();
    check("rst_mid_no_done", 32'(done), 32'd0);
    run_walk(sos, 0, 1'b0, 15);

    for (int w = 0; w < 8; w++) begin
      seq = '1;
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0:       code = 10'h3FF;
          1, 2:    code = encode(morse[$urandom_range(0, 35)]);
          default: code = 10'($urandom);
        endcase
        seq[k*10 +: 10] = code;
      end
      run_walk(seq, 1, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
